instruction_decode_stage: RTL and testbench

Second stage of the four-stage pipelined MIPS core (fetch → decode → execute → memory/writeback). Registers the pre-decoded instruction fields from the fetch stage and reads operands from a 32×32 register file. It also muxes immediates into operand B and presents source register indices so the execute stage can forward. It owns the architectural register file, which the memory/writeback stage writes through a dedicated port, and it generates the core-level completion flag.

---
 rtl/mips_pkg.sv | 32 +++
 rtl/reg_file.sv | 46 ++++
 rtl/instruction_decode_stage.sv | 118 +++++++++++
 tb/tb_instruction_decode_stage.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: widths, instruction type codes and
// the decode-to-execute bundle.
package mips_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;
  localparam int TY_W   = 4;

  localparam logic [TY_W-1:0] TY_NOP  = 4'd0;
  localparam logic [TY_W-1:0] TY_ADD  = 4'd1;
  localparam logic [TY_W-1:0] TY_SUB  = 4'd2;
  localparam logic [TY_W-1:0] TY_AND  = 4'd3;
  localparam logic [TY_W-1:0] TY_OR   = 4'd4;
  localparam logic [TY_W-1:0] TY_SLT  = 4'd5;
  localparam logic [TY_W-1:0] TY_ADDI = 4'd6;
  localparam logic [TY_W-1:0] TY_SW   = 4'd7;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [REG_W-1:0]  src_a;
    logic [REG_W-1:0]  src_b;
    logic [REG_W-1:0]  wb_tgt;
    logic [TY_W-1:0]   itype;
    logic [15:0]       sw_off;
  } id_ex_t;

  function automatic logic is_rtype(input logic [TY_W-1:0] t);
    return (t >= TY_ADD) && (t <= TY_SLT);
  endfunction

endpackage

// File: rtl/reg_file.sv
// 32x32 architectural register file: one write port, two combinational
// read ports with same-cycle write bypass; r0 is hardwired to zero.
module reg_file
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [REG_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_W-1:0]  raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [REG_W-1:0]  raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem_q [32];
  logic              wr_ok;

  assign wr_ok = we && (waddr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mem_q[i] <= '0;
    end else if (wr_ok) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_a = mem_q[raddr_a];
    if (raddr_a == '0)
      rdata_a = '0;
    else if (wr_ok && waddr == raddr_a)
      rdata_a = wdata;
  end

  always_comb begin
    rdata_b = mem_q[raddr_b];
    if (raddr_b == '0)
      rdata_b = '0;
    else if (wr_ok && waddr == raddr_b)
      rdata_b = wdata;
  end

endmodule

// File: rtl/instruction_decode_stage.sv
// MIPS decode stage: operand fetch from the register file, immediate
// muxing, pipeline registers toward execute and sticky done flags.
module instruction_decode_stage
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              done_in_ID,
  input  logic              done_in_WB,
  input  logic              wb_en,
  input  logic [REG_W-1:0]  wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [REG_W-1:0]  rs,
  input  logic [REG_W-1:0]  rt,
  input  logic [REG_W-1:0]  rd,
  input  logic [DATA_W-1:0] imm,
  input  logic              has_rs,
  input  logic              has_rt,
  input  logic              has_rd,
  input  logic              has_imm,
  input  logic [TY_W-1:0]   instr_type_IF,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [REG_W-1:0]  sourceA,
  output logic [REG_W-1:0]  sourceB,
  output logic [REG_W-1:0]  wb_tgt_ID,
  output logic [TY_W-1:0]   instr_type_ID,
  output logic [15:0]       sw_offset,
  output logic              done_ID,
  output logic              done_WB
);

  logic [REG_W-1:0]  src_a;
  logic [DATA_W-1:0] rdata_a;
  logic [DATA_W-1:0] rdata_b;
  logic              is_r;
  logic              is_addi;
  logic              is_sw;
  id_ex_t            ex_d;
  id_ex_t            ex_q;
  logic              done_id_q;
  logic              done_wb_q;
  logic              unused_fields;

  // Validity of rt/imm is implied by the type code.
  assign unused_fields = has_rt ^ has_imm;

  assign src_a = has_rs ? rs : '0;

  reg_file u_rf (
    .clk     (clk),
    .rst_n   (reset),
    .we      (wb_en),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .raddr_a (src_a),
    .rdata_a (rdata_a),
    .raddr_b (rt),
    .rdata_b (rdata_b)
  );

  assign is_r    = !done_in_ID && is_rtype(instr_type_IF);
  assign is_addi = !done_in_ID && (instr_type_IF == TY_ADDI);
  assign is_sw   = !done_in_ID && (instr_type_IF == TY_SW);

  always_comb begin
    ex_d = '0;
    unique case (1'b1)
      is_r: begin
        ex_d.a      = rdata_a;
        ex_d.src_a  = src_a;
        ex_d.b      = rdata_b;
        ex_d.src_b  = rt;
        ex_d.wb_tgt = has_rd ? rd : '0;
        ex_d.itype  = instr_type_IF;
      end
      is_addi: begin
        ex_d.a      = rdata_a;
        ex_d.src_a  = src_a;
        ex_d.b      = imm;
        ex_d.wb_tgt = rt;
        ex_d.itype  = TY_ADDI;
      end
      is_sw: begin
        ex_d.a      = rdata_a;
        ex_d.src_a  = src_a;
        ex_d.b      = rdata_b;
        ex_d.src_b  = rt;
        ex_d.itype  = TY_SW;
        ex_d.sw_off = imm[15:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q      <= '0;
      done_id_q <= 1'b0;
      done_wb_q <= 1'b0;
    end else begin
      ex_q      <= ex_d;
      done_id_q <= done_id_q | done_in_ID;
      done_wb_q <= done_wb_q | done_in_WB;
    end
  end

  assign A             = ex_q.a;
  assign B             = ex_q.b;
  assign sourceA       = ex_q.src_a;
  assign sourceB       = ex_q.src_b;
  assign wb_tgt_ID     = ex_q.wb_tgt;
  assign instr_type_ID = ex_q.itype;
  assign sw_offset     = ex_q.sw_off;
  assign done_ID       = done_id_q;
  assign done_WB       = done_wb_q;

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Scoreboard bench for instruction_decode_stage: a behavioural model
// predicts each decode result, a monitor compares after every edge.
module tb_instruction_decode_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        done_in_ID = 0, done_in_WB = 0;
  logic        wb_en = 0;
  logic [4:0]  wb_addr = 0;
  logic [31:0] wb_data = 0;
  logic [4:0]  rs = 0, rt = 0, rd = 0;
  logic [31:0] imm = 0;
  logic        has_rs = 0, has_rt = 0, has_rd = 0, has_imm = 0;
  logic [3:0]  instr_type_IF = 0;
  logic [31:0] A, B;
  logic [4:0]  sourceA, sourceB, wb_tgt_ID;
  logic [3:0]  instr_type_ID;
  logic [15:0] sw_offset;
  logic        done_ID, done_WB;

  instruction_decode_stage dut (
    .clk(clk), .reset(reset),
    .done_in_ID(done_in_ID), .done_in_WB(done_in_WB),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .rs(rs), .rt(rt), .rd(rd), .imm(imm),
    .has_rs(has_rs), .has_rt(has_rt), .has_rd(has_rd),
    .has_imm(has_imm), .instr_type_IF(instr_type_IF),
    .A(A), .B(B), .sourceA(sourceA), .sourceB(sourceB),
    .wb_tgt_ID(wb_tgt_ID), .instr_type_ID(instr_type_ID),
    .sw_offset(sw_offset), .done_ID(done_ID), .done_WB(done_WB)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a, b;
    logic [4:0]  sa, sb, tgt;
    logic [3:0]  ty;
    logic [15:0] so;
    logic        di, dw;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_rf [32];
  logic        m_di, m_dw;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] idx,
      input logic wen, input logic [4:0] wa, input logic [31:0] wd);
    if (idx == 0) return 32'd0;
    if (wen && wa == idx) return wd;
    return m_rf[idx];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    m_di = 0;
    m_dw = 0;
  endtask

  task automatic issue(input logic [3:0] ty, input logic [4:0] rs_,
      input logic [4:0] rt_, input logic [4:0] rd_, input logic [31:0] im,
      input logic hrs, input logic hrd, input logic wen,
      input logic [4:0] wa, input logic [31:0] wd,
      input logic din_id, input logic din_wb);
    exp_t e;
    int   t;
    @(negedge clk);
    instr_type_IF = ty; rs = rs_; rt = rt_; rd = rd_; imm = im;
    has_rs = hrs; has_rt = 1'b1; has_rd = hrd; has_imm = 1'b1;
    wb_en = wen; wb_addr = wa; wb_data = wd;
    done_in_ID = din_id; done_in_WB = din_wb;
    t = (din_id || ty > 7) ? 0 : int'(ty);
    e = '{a: 0, b: 0, sa: 0, sb: 0, tgt: 0, ty: 4'(t), so: 0,
          di: m_di | din_id, dw: m_dw | din_wb};
    if (t != 0) begin
      e.sa = hrs ? rs_ : 5'd0;
      e.a  = m_read(e.sa, wen, wa, wd);
      if (t == 6) begin
        e.b   = im;
        e.tgt = rt_;
      end else begin
        e.b  = m_read(rt_, wen, wa, wd);
        e.sb = rt_;
        if (t == 7) e.so = im[15:0];
        else        e.tgt = hrd ? rd_ : 5'd0;
      end
    end
    q.push_back(e);
    if (wen && wa != 0) m_rf[wa] = wd;
    m_di = e.di;
    m_dw = e.dw;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 0;
    wb_en = 1; wb_addr = 5'd9; wb_data = 32'hDEAD_BEEF;
    instr_type_IF = 4'd1;
    model_clear();
    #1;
    chk("rst_A", A, 0);
    chk("rst_B", B, 0);
    chk("rst_srcs", {17'd0, sourceA, sourceB, wb_tgt_ID}, 0);
    chk("rst_ty_off", {12'd0, instr_type_ID, sw_offset}, 0);
    chk("rst_done", {30'd0, done_ID, done_WB}, 0);
    #1;
    wb_en = 0;
    instr_type_IF = 4'd0;
    done_in_ID = 0; done_in_WB = 0;
    reset = 1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("A", A, e.a);
        chk("B", B, e.b);
        chk("sourceA", 32'(sourceA), 32'(e.sa));
        chk("sourceB", 32'(sourceB), 32'(e.sb));
        chk("wb_tgt_ID", 32'(wb_tgt_ID), 32'(e.tgt));
        chk("instr_type_ID", 32'(instr_type_ID), 32'(e.ty));
        chk("sw_offset", 32'(sw_offset), 32'(e.so));
        chk("done_ID", 32'(done_ID), 32'(e.di));
        chk("done_WB", 32'(done_WB), 32'(e.dw));
      end
    end
  end

  initial begin : stim
    logic [4:0] r_rs, r_wa;
    model_clear();
    #12;
    reset = 1;
    // writeback then read, ADD r3=r1+r2
    issue(0, 0, 0, 0, 0, 0, 0, 1, 5'd1, 32'd5, 0, 0);
    issue(0, 0, 0, 0, 0, 0, 0, 1, 5'd2, 32'd7, 0, 0);
    issue(1, 5'd1, 5'd2, 5'd3, 0, 1, 1, 0, 0, 0, 0, 0);
    // same-edge bypass into SUB
    issue(2, 5'd4, 5'd2, 5'd5, 0, 1, 1, 1, 5'd4, 32'h1234, 0, 0);
    // ADDI with negative immediate
    issue(6, 5'd1, 5'd6, 0, 32'hFFFF_FFFE, 1, 0, 0, 0, 0, 0, 0);
    // SW base r2, data r1, offset 8
    issue(7, 5'd2, 5'd1, 5'd9, 32'd8, 1, 1, 0, 0, 0, 0, 0);
    // r0 write ignored, both same-edge and later
    issue(1, 5'd0, 5'd0, 5'd7, 0, 1, 1, 1, 5'd0, 32'hFF, 0, 0);
    issue(4, 5'd0, 5'd0, 5'd7, 0, 1, 1, 0, 0, 0, 0, 0);
    // unknown type and has_* clear
    issue(4'd12, 5'd1, 5'd2, 5'd3, 32'h55, 1, 1, 0, 0, 0, 0, 0);
    issue(3, 5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 0, 0, 0, 0);
    // done pulses, then normal decode continues
    issue(1, 5'd1, 5'd2, 5'd3, 0, 1, 1, 0, 0, 0, 1, 0);
    issue(5, 5'd1, 5'd2, 5'd3, 0, 1, 1, 1, 5'd8, 32'd3, 0, 1);
    issue(1, 5'd8, 5'd2, 5'd3, 0, 1, 1, 0, 0, 0, 0, 0);
    // reset mid-program, then ADD r3=r1+r2 reads zeros
    do_reset();
    issue(1, 5'd1, 5'd2, 5'd3, 0, 1, 1, 0, 0, 0, 0, 0);
    issue(1, 5'd9, 5'd9, 5'd3, 0, 1, 1, 0, 0, 0, 0, 0);
    for (int n = 0; n < 1500; n++) begin
      if (n % 400 == 399) do_reset();
      r_rs = 5'($urandom_range(0, 31));
      r_wa = ($urandom_range(0, 3) == 0) ? r_rs : 5'($urandom_range(0, 31));
      issue(4'($urandom_range(0, 15)), r_rs, 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), $urandom(),
            ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0),
            ($urandom_range(0, 2) != 0), r_wa, $urandom(),
            ($urandom_range(0, 60) == 0), ($urandom_range(0, 60) == 0));
    end
    @(negedge clk);
    wb_en = 0;
    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
